// File: rtl/linear_dist_ctrl_pkg.sv
// Shared defaults and helpers for the linear_dist sequencer.
package ldc_pkg;

  localparam int LDC_NUM_PES    = 4;
  localparam int LDC_DATA_TYPE  = 16;
  localparam int LDC_FIFO_DEPTH = 8;
  // Registered adder stages in a default-width linear_dist chain
  localparam int CHAIN_LAT      = LDC_NUM_PES - 1;

  // Ceiling log2; clog2(1) = 0
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

  // LSB index of a lane inside a packed vector
  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/linear_dist_ctrl_if.sv
// Input-vector and result handshakes of the linear_dist sequencer.
interface linear_dist_ctrl_if
  import ldc_pkg::*;
#(
  parameter int NUM_PES   = LDC_NUM_PES,
  parameter int DATA_TYPE = LDC_DATA_TYPE
);
  logic                           in_valid;
  logic                           in_ready;
  logic [NUM_PES*DATA_TYPE-1:0]   in_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [DATA_TYPE-1:0]           out_data;

  // Producer/consumer side
  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  // Controller side
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/linear_dist_ctrl_result_fifo.sv
// Result FIFO with occupancy count; head reads as zero when empty.
module ldc_result_fifo
  import ldc_pkg::*;
#(
  parameter int DEPTH = LDC_FIFO_DEPTH,
  parameter int W     = LDC_DATA_TYPE,
  localparam int AW   = clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;   // pop on empty is ignored
  assign dout   = empty ? '0 : mem[rptr];

  // Pointers and count; push+pop leaves count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)   wptr <= wptr + AW'(1);
      if (do_pop) rptr <= rptr + AW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage, not reset: only entries below count are ever visible
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  // Credit accounting upstream must make a push into a full FIFO impossible
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(push && (count == CW'(DEPTH))));
  end

endmodule

// File: rtl/linear_dist_ctrl.sv
// Sequencer for the linear_dist reduction chain: skews lanes into the chain,
// tracks launches with a valid pipe and buffers results behind credits.
module linear_dist_ctrl
  import ldc_pkg::*;
#(
  parameter int NUM_PES    = LDC_NUM_PES,
  parameter int DATA_TYPE  = LDC_DATA_TYPE,
  parameter int FIFO_DEPTH = LDC_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  linear_dist_ctrl_if.slave            bus,
  output logic [NUM_PES*DATA_TYPE-1:0] dist_data,
  input  logic [DATA_TYPE-1:0]         dist_result,
  output logic                         busy
);
  localparam int STAGES = NUM_PES - 1;
  localparam int CW     = clog2(FIFO_DEPTH) + 1;

  logic            fire, push;
  logic [STAGES:1] vld_q;
  logic [STAGES:0] vld_pipe;
  logic [CW-1:0]   inflight, fifo_count, credit_sum;
  logic            fifo_empty;

  // Credits come from registers only, so out_ready never reaches in_ready
  assign credit_sum   = fifo_count + inflight;
  assign bus.in_ready = credit_sum < CW'(FIFO_DEPTH);
  assign fire         = bus.in_valid && bus.in_ready;

  // Bit k is high while the vector accepted k cycles ago sits at skew/chain position k
  assign vld_pipe = {vld_q, fire};
  assign push     = vld_pipe[STAGES];

  // Valid shift register tracking each launch through the chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_pipe[STAGES-1:0];
  end

  // Vectors accepted but not yet written into the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= '0;
    else begin
      case ({fire, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Per-lane skew: capture register plus i-1 delay registers for lane i >= 2.
  // Each register only advances when its position holds a valid vector, so
  // values persist until the next vector reaches the same position.
  for (genvar i = 0; i < NUM_PES; i++) begin : g_lane
    localparam int DL = (i < 2) ? 0 : i - 1;
    logic [DL:0][DATA_TYPE-1:0] line;

    // Capture and delay line for this lane
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) line <= '0;
      else begin
        if (vld_pipe[0]) line[0] <= bus.in_data[lane_lo(i, DATA_TYPE) +: DATA_TYPE];
        for (int k = 1; k <= DL; k++)
          if (vld_pipe[k]) line[k] <= line[k-1];
      end
    end

    assign dist_data[lane_lo(i, DATA_TYPE) +: DATA_TYPE] = line[DL];
  end

  ldc_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_TYPE)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (dist_result),
    .pop   (bus.out_ready),
    .dout  (bus.out_data),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;
  assign busy          = (|vld_q) || !fifo_empty;

endmodule

// File: tb/tb_linear_dist_ctrl.sv
// Directed bench for linear_dist_ctrl with a behavioural linear_dist chain.
// The chain keeps the highest-indexed odd lane (lane0 if none is odd).
module tb_linear_dist_ctrl;
  localparam int NP = 4;
  localparam int DW = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NP*DW-1:0] dist_data;
  logic [DW-1:0]    dist_result;
  logic             busy;
  int               n_chk = 0;
  int               n_pass = 0;

  linear_dist_ctrl_if #(.NUM_PES(NP), .DATA_TYPE(DW)) bus ();

  linear_dist_ctrl #(.NUM_PES(NP), .DATA_TYPE(DW), .FIFO_DEPTH(8)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dist_data   (dist_data),
    .dist_result (dist_result),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] lane(input logic [NP*DW-1:0] v, input int i);
    return v[i*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] pick(input logic [DW-1:0] acc, input logic [DW-1:0] l);
    return l[0] ? l : acc;
  endfunction

  // linear_dist model: lanes 0/1 meet in stage 1, lane2 in stage 2, lane3 at the output
  logic [DW-1:0] s1, s2;
  always @(posedge clk) begin
    s1 <= pick(lane(dist_data, 0), lane(dist_data, 1));
    s2 <= pick(s1, lane(dist_data, 2));
  end
  assign dist_result = pick(s2, lane(dist_data, 3));

  // Vector whose only odd lane is k%4, carrying 0x0A01+2k; that value is the result
  function automatic logic [NP*DW-1:0] mkvec(input int k);
    logic [NP*DW-1:0] v;
    for (int j = 0; j < NP; j++)
      v[j*DW +: DW] = (j == k % 4) ? DW'(16'h0A01 + 2*k) : DW'(16'h0100*j + 2*k);
    return v;
  endfunction

  function automatic logic [DW-1:0] mkexp(input int k);
    return DW'(16'h0A01 + 2*k);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    tick(); tick();
    n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b exp 1", bus.in_ready); else n_pass++;
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b exp 0", bus.out_valid); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else n_pass++;
    n_chk++; if (dist_data !== '0) $display("FAIL rst_dist_data: got %h exp 0", dist_data); else n_pass++;
    rst_n = 1'b1;
    tick();
    n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b exp 1", bus.in_ready); else n_pass++;
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL post_rst_out_valid: got %b exp 0", bus.out_valid); else n_pass++;
    n_chk++; if (bus.out_data !== 16'h0) $display("FAIL post_rst_out_data: got %h exp 0", bus.out_data); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL post_rst_busy: got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_single();
    logic [NP*DW-1:0] vecs [3];
    logic [DW-1:0]    exps [3];
    vecs[0] = {16'h0005, 16'h0002, 16'h0010, 16'h0004}; exps[0] = 16'h0005;
    vecs[1] = {16'h0008, 16'h0007, 16'h0010, 16'h0004}; exps[1] = 16'h0007;
    vecs[2] = {16'h0008, 16'h0006, 16'h0010, 16'h0003}; exps[2] = 16'h0003;
    for (int n = 0; n < 3; n++) begin
      n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL single_in_ready[%0d]: got %b exp 1", n, bus.in_ready); else n_pass++;
      bus.in_valid = 1'b1;
      bus.in_data = vecs[n];
      tick();                       // cycle c+1
      bus.in_valid = 1'b0;
      n_chk++; if (dist_data[2*DW-1:0] !== vecs[n][2*DW-1:0])
        $display("FAIL single_lane01[%0d]: got %h exp %h", n, dist_data[2*DW-1:0], vecs[n][2*DW-1:0]); else n_pass++;
      n_chk++; if (busy !== 1'b1) $display("FAIL single_busy[%0d]: got %b exp 1", n, busy); else n_pass++;
      tick();                       // cycle c+2
      n_chk++; if (lane(dist_data, 2) !== lane(vecs[n], 2))
        $display("FAIL single_lane2[%0d]: got %h exp %h", n, lane(dist_data, 2), lane(vecs[n], 2)); else n_pass++;
      tick();                       // cycle c+3
      n_chk++; if (lane(dist_data, 3) !== lane(vecs[n], 3))
        $display("FAIL single_lane3[%0d]: got %h exp %h", n, lane(dist_data, 3), lane(vecs[n], 3)); else n_pass++;
      n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL single_early_valid[%0d]: got %b exp 0", n, bus.out_valid); else n_pass++;
      tick();                       // cycle c+4
      n_chk++; if (bus.out_valid !== 1'b1 || bus.out_data !== exps[n])
        $display("FAIL single_result[%0d]: got v=%b d=%h exp v=1 d=%h", n, bus.out_valid, bus.out_data, exps[n]); else n_pass++;
      tick();
      n_chk++; if (bus.out_valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL single_drained[%0d]: got v=%b busy=%b exp 0 0", n, bus.out_valid, busy); else n_pass++;
    end
  endtask

  task automatic test_stream();
    for (int t = 0; t <= 24; t++) begin
      if (t >= 4 && t < 24) begin
        n_chk++; if (bus.out_valid !== 1'b1 || bus.out_data !== mkexp(t-4))
          $display("FAIL stream_result[%0d]: got v=%b d=%h exp v=1 d=%h", t-4, bus.out_valid, bus.out_data, mkexp(t-4)); else n_pass++;
      end
      if (t < 20) begin
        n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d]: got %b exp 1", t, bus.in_ready); else n_pass++;
        bus.in_valid = 1'b1;
        bus.in_data = mkvec(t);
      end else begin
        bus.in_valid = 1'b0;
      end
      if (t == 24) begin
        n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL stream_tail_valid: got %b exp 0", bus.out_valid); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 14; t++) begin
      bus.in_data = mkvec(40 + acc);
      if (bus.in_ready === 1'b1) acc++;
      tick();
    end
    n_chk++; if (acc !== 8) $display("FAIL bp_accepts: got %0d exp 8", acc); else n_pass++;
    n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready_low: got %b exp 0", bus.in_ready); else n_pass++;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      n_chk++; if (bus.out_valid !== 1'b1 || bus.out_data !== mkexp(40 + j))
        $display("FAIL bp_drain[%0d]: got v=%b d=%h exp v=1 d=%h", j, bus.out_valid, bus.out_data, mkexp(40 + j)); else n_pass++;
      if (j < 2) begin
        n_chk++; if (bus.in_ready !== (j == 1))
          $display("FAIL bp_credit_return[%0d]: got %b exp %b", j, bus.in_ready, (j == 1)); else n_pass++;
      end
      tick();
    end
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL bp_empty: got %b exp 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_push_pop();
    // A,B,C fill the FIFO to 3, then D's push coincides with A's pop
    bus.out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      bus.in_valid = 1'b1;
      bus.in_data = mkvec(60 + n);
      tick();
    end
    bus.in_valid = 1'b0;
    tick(); tick(); tick();          // C written; FIFO holds A,B,C
    n_chk++; if (bus.out_valid !== 1'b1 || bus.out_data !== mkexp(60))
      $display("FAIL pp_head_a: got v=%b d=%h exp v=1 d=%h", bus.out_valid, bus.out_data, mkexp(60)); else n_pass++;
    bus.in_valid = 1'b1;
    bus.in_data = mkvec(63);          // D accepted in cycle d
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();                   // cycle d+3: D pushed at its end
    bus.out_ready = 1'b1;             // pop A in the same cycle
    tick();
    bus.out_ready = 1'b0;
    for (int n = 1; n < 4; n++) begin
      n_chk++; if (bus.out_valid !== 1'b1 || bus.out_data !== mkexp(60 + n))
        $display("FAIL pp_order[%0d]: got v=%b d=%h exp v=1 d=%h", n, bus.out_valid, bus.out_data, mkexp(60 + n)); else n_pass++;
      bus.out_ready = 1'b1;
      tick();
    end
    n_chk++; if (bus.out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL pp_count3: got v=%b busy=%b exp 0 0", bus.out_valid, busy); else n_pass++;
  endtask

  task automatic test_mid_reset();
    bus.out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      bus.in_valid = 1'b1;
      bus.in_data = mkvec(80 + n);
      tick();
    end
    bus.in_valid = 1'b0;              // 2 in FIFO, 3 in flight
    n_chk++; if (bus.out_valid !== 1'b1 || busy !== 1'b1)
      $display("FAIL mr_loaded: got v=%b busy=%b exp 1 1", bus.out_valid, busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1 || dist_data !== '0)
      $display("FAIL mr_async: got v=%b busy=%b rdy=%b dd=%h exp 0 0 1 0", bus.out_valid, busy, bus.in_ready, dist_data); else n_pass++;
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();
      n_chk++; if (bus.out_valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL mr_spurious[%0d]: got v=%b busy=%b exp 0 0", t, bus.out_valid, busy); else n_pass++;
    end
    bus.in_valid = 1'b1;
    bus.in_data = {16'h0000, 16'h0000, 16'h0000, 16'h0001};
    tick();
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    n_chk++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0001)
      $display("FAIL mr_new_result: got v=%b d=%h exp v=1 d=0001", bus.out_valid, bus.out_data); else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_push_pop();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1);
  end

endmodule

// File: doc/linear_dist_ctrl.md
Name: linear_dist_ctrl

Overview:
Sequencer for the linear_dist reduction chain (NUM_PES-1 registered adder stages, no stall, no valid). It accepts whole input vectors over a valid/ready handshake and skews each lane so it meets the partial result at the correct stage. It tracks each launch through the chain and captures the result into a credit-protected output FIFO, so nothing is lost when the consumer backpressures. It sits between the PE array and one linear_dist instance.

Parameters:
NUM_PES, 4, lanes per vector / chain width; must be >= 2
DATA_TYPE, 16, bits per lane
FIFO_DEPTH, 8, result FIFO entries; power of 2; >= NUM_PES+1 for full throughput

Ports:
clk  in  1  clock; all flops on posedge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input vector valid
in_ready  out  1  controller can accept a vector
in_data  in  NUM_PES*DATA_TYPE  lane i at [(i+1)*DATA_TYPE-1 : i*DATA_TYPE]
dist_data  out  NUM_PES*DATA_TYPE  to linear_dist data_in; skewed, registered
dist_result  in  DATA_TYPE  from linear_dist data_out
out_valid  out  1  result FIFO non-empty
out_ready  in  1  consumer accepts out_data
out_data  out  DATA_TYPE  FIFO head
busy  out  1  any vector in skew/chain or FIFO non-empty

Behaviour:
- Reset (async assert, sync release): dist_data=0, skew regs=0, valid pipe=0, FIFO empty, counts=0. Outputs: in_ready=1, out_valid=0, busy=0, out_data=0.
- Accept when in_valid && in_ready at edge e (cycle c).
- Launch cycle L = c+1: lanes 0 and 1 appear on dist_data in cycle L.
- Lane i >= 2 appears in cycle L+i-1. Lane i has its own delay line of i-1 registers after the capture register.
- Each lane register holds its value until overwritten by the next accepted vector at the same skew position. With back-to-back vectors, lanes of different vectors coexist on dist_data; this is intended.
- Valid pipe: 1-bit shift register, length NUM_PES, bit0 set at accept. When the tail bit is 1, dist_result is written into the FIFO at the end of cycle L+NUM_PES-2, i.e. cycle c+NUM_PES-1. out_valid rises at cycle c+NUM_PES.
- Accept-to-out_valid latency is therefore NUM_PES cycles (4 for defaults).
- Chain flops are not reset. Garbage in the chain is ignored because its valid bit is 0.
- Credit: inflight = accepted vectors not yet written into the FIFO (0..NUM_PES).
  - in_ready = (fifo_count + inflight) < FIFO_DEPTH, computed combinationally from registers only; no path from out_ready.
  - A pop in cycle k frees a credit visible in cycle k+1.
  - FIFO overflow is impossible by construction. Implementations must assert on it in simulation.
- Simultaneous events:
  - Accept + chain-exit in the same cycle: inflight unchanged.
  - FIFO push + pop in the same cycle: count unchanged; a push into an empty FIFO with out_ready=1 does not bypass.
  - Pop when empty: ignored.
- Result order equals accept order.
- Throughput: 1 vector/cycle when out_ready=1 and FIFO_DEPTH >= NUM_PES+1.
- busy = |valid_pipe || fifo_count != 0.
- Mid-operation rst_n assertion drops all in-flight and buffered results immediately. Post-reset outputs then match the reset values above.
- Widths: fifo_count and the credit sum are $clog2(FIFO_DEPTH)+1 bits; pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.

Decomposition:
- Package ldc_pkg:
  - function clog2
  - localparam CHAIN_LAT = NUM_PES-1, the stage count
  - lane slice helper function
- One sub-module: ldc_result_fifo, a synchronous FIFO with count, async active-low reset, and the same clk/rst_n names. Skew lines, valid pipe and credit logic stay in linear_dist_ctrl.

Test Plan:
(Bench instantiates linear_dist with defaults NUM_PES=4, DATA_TYPE=16, out_ready=1 unless stated.)
1. Reset: rst_n=0 then released -> in_ready=1, out_valid=0, busy=0, dist_data=0.
2. Single vector {lane3..0}={0x0005,0x0002,0x0010,0x0004}, accepted in cycle c -> out_valid in cycle c+4 with out_data=0x0005 (lane3 odd). Then {0x0008,0x0007,0x0010,0x0004} -> 0x0007. Then {0x0008,0x0006,0x0010,0x0003} -> 0x0003. Check skew: lane2 appears at c+2, lane3 at c+3.
3. Streaming: 20 back-to-back vectors -> in_ready stays 1, 20 results in order, one per cycle, starting at c+4.
4. Backpressure: out_ready=0, FIFO_DEPTH=8, continuous in_valid -> exactly 8 accepts, then in_ready=0. No loss; 8 results drain in order once out_ready=1. in_ready returns the cycle after the first pop.
5. Simultaneous push/pop with FIFO at count 3 -> count stays 3, ordering preserved.
6. Reset mid-stream with 3 vectors in the chain and 2 in the FIFO -> all dropped. After release, no spurious out_valid within 6 cycles. A new vector {0,0,0,0x0001} returns 0x0001.
